digit_serial_adder: RTL and testbench

Multi-cycle, parametrised two's-complement adder/subtractor that processes a WIDTH-bit operand pair DIGIT bits per clock, carrying between digits in a register. It is the area-reduced successor to the fixed 8-bit ripple adder. It is used wherever wide additions are infrequent enough to trade latency for a narrow carry chain. Operation is a start/busy/done handshake; the result is held until the next completion.

---
 rtl/digit_serial_adder_pkg.sv | 19 +
 rtl/digit_serial_adder_digit_adder.sv | 36 +++
 rtl/digit_serial_adder.sv | 139 +++++++++++++
 tb/tb_digit_serial_adder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_serial_adder_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package digit_serial_adder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Counter width for a given digit count; a single-digit adder still needs a 1-bit counter.
    function automatic int cnt_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DIGIT = 8;
    localparam int NDIG      = DEF_WIDTH / DEF_DIGIT;
    localparam int CNT_W     = cnt_width(NDIG);

endpackage

// File: rtl/digit_serial_adder_digit_adder.sv
// One-bit full-adder cell and the DIGIT-bit ripple adder built from it.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module digit_adder #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);
    logic [DIGIT:0] c;

    assign c[0] = ci;
    assign co   = c[DIGIT];

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end
endmodule

// File: rtl/digit_serial_adder.sv
// Two's-complement adder/subtractor that adds DIGIT bits per clock over
// WIDTH/DIGIT cycles, with a start/busy/done handshake and held results.
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NUM_DIG   = (DIGIT >= 1) ? WIDTH / DIGIT : 1;
    localparam int CNT_WIDTH = cnt_width(NUM_DIG);

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $fatal(1, "digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
    end

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;      // already inverted for subtraction
    logic [WIDTH-1:0]       res_q, res_d;  // partially assembled result
    logic [WIDTH-1:0]       sum_q, sum_d;
    logic                   carry_q, carry_d;
    logic                   cout_q, cout_d;
    logic                   ovf_q, ovf_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [DIGIT-1:0]       dig_a, dig_b, dig_s;
    logic                   dig_co;
    int                     dig_base;

    assign dig_base = int'(cnt_q) * DIGIT;
    assign dig_a    = a_q[dig_base +: DIGIT];
    assign dig_b    = b_q[dig_base +: DIGIT];

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .a  (dig_a),
        .b  (dig_b),
        .ci (carry_q),
        .s  (dig_s),
        .co (dig_co)
    );

    // Next-state logic: accept in IDLE, add one digit per cycle in RUN, publish on the last digit.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[dig_base +: DIGIT] = dig_s;
                carry_d = dig_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_WIDTH'(NUM_DIG - 1)) begin
                    sum_d   = res_d;
                    cout_d  = dig_co;
                    // Carry into the MSB recovered from its sum bit, compared with the carry out.
                    ovf_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ res_d[WIDTH-1] ^ dig_co;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything so an aborted operation leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: operand/result registers are reset too; reset must show sum=0, and stale operands are never observable anyway.
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder: 32/8 main instance and an 8/8 single-digit instance.
module tb_digit_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start, cin, sub;
    logic [31:0] a, b;
    logic        busy, done, cout, ovf;
    logic [31:0] sum;

    logic        start8, cin8, sub8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  sum8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(32), .DIGIT(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic, signed overflow from operand/result signs.
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s);
        logic [31:0] y_eff;
        logic [32:0] full;
        res_t r;
        y_eff  = s ? ~y : y;
        full   = {1'b0, x} + {1'b0, y_eff} + 33'(s ? 1'b1 : c);
        r.sum  = full[31:0];
        r.cout = full[32];
        r.ovf  = (x[31] == y_eff[31]) && (r.sum[31] != x[31]);
        return r;
    endfunction

    // Start one operation on the 32-bit instance; report edges-to-done and busy cycles.
    task automatic run_op(input logic [31:0] a_i, input logic [31:0] b_i, input logic cin_i,
                          input logic sub_i, output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        @(negedge clk);
        a = a_i; b = b_i; cin = cin_i; sub = sub_i; start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) bcnt++;
        end
    endtask

    task automatic run_op8(input logic [7:0] a_i, input logic [7:0] b_i, input logic cin_i,
                           input logic sub_i, output int lat);
        lat = -1;
        @(negedge clk);
        a8 = a_i; b8 = b_i; cin8 = cin_i; sub8 = sub_i; start8 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (done8) begin
                lat = i;
                break;
            end
        end
    endtask

    vec_t vecs[7];

    initial begin
        int lat, bcnt, t1, t2, extra;
        res_t r;

        vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[6] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};

        rst_n = 1'b0;
        start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;

        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum",  sum,  0);
        check("rst_cout", cout, 0);
        check("rst_ovf",  ovf,  0);
        check("rst8_sum", sum8, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat, bcnt);
            check($sformatf("vec%0d_sum", i),  sum,  vecs[i].sum);
            check($sformatf("vec%0d_cout", i), cout, vecs[i].cout);
            check($sformatf("vec%0d_ovf", i),  ovf,  vecs[i].ovf);
            check($sformatf("vec%0d_lat", i),  lat,  4);
            check($sformatf("vec%0d_busy", i), bcnt, 4);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), done, 0);
        end

        // Randomized against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            logic [31:0] ra, rb;
            logic rc, rs;
            ra = $urandom; rb = $urandom;
            rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            r = model(ra, rb, rc, rs);
            run_op(ra, rb, rc, rs, lat, bcnt);
            check($sformatf("rnd%0d_sum", i),  sum,  r.sum);
            check($sformatf("rnd%0d_cout", i), cout, r.cout);
            check($sformatf("rnd%0d_ovf", i),  ovf,  r.ovf);
            check($sformatf("rnd%0d_lat", i),  lat,  4);
        end

        // start re-pulsed mid-RUN with other operands is ignored
        r = model(32'h0F0F_0F0F, 32'h1010_1010, 1'b1, 1'b0);
        @(negedge clk);
        a = 32'h0F0F_0F0F; b = 32'h1010_1010; cin = 1'b1; sub = 1'b0; start = 1'b1;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 1) begin
                a = 32'hFFFF_0000; b = 32'h1234_5678; sub = 1'b1; start = 1'b1;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        check("repulse_lat", lat, 4);
        check("repulse_sum", sum, r.sum);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        check("repulse_no_second_op", extra, 0);

        // start held high: second operation accepted in the done cycle
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
        t1 = -1; t2 = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 0) begin
                a = 32'hDEAD_BEEF; b = 32'h0102_0304; sub = 1'b1;
            end
            if (i == 5) start = 1'b0;
            if (done) begin
                if (t1 < 0) begin
                    t1 = i;
                    r = model(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
                    check("b2b_first_sum", sum, r.sum);
                end else if (t2 < 0) begin
                    t2 = i;
                    r = model(32'hDEAD_BEEF, 32'h0102_0304, 1'b0, 1'b1);
                    check("b2b_second_sum", sum, r.sum);
                    check("b2b_second_cout", cout, r.cout);
                end
            end
        end
        start = 1'b0;
        check("b2b_first_lat", t1, 4);
        check("b2b_spacing", t2 - t1, 5);

        // Reset while digit 2 is being added: no done, outputs cleared
        @(negedge clk);
        a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum",  sum,  0);
        check("abort_cout", cout, 0);
        check("abort_ovf",  ovf,  0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        check("abort_no_done", extra, 0);
        check("abort_sum_held", sum, 0);

        r = model(32'hCAFE_F00D, 32'h3501_0FF3, 1'b1, 1'b0);
        run_op(32'hCAFE_F00D, 32'h3501_0FF3, 1'b1, 1'b0, lat, bcnt);
        check("post_abort_sum",  sum,  r.sum);
        check("post_abort_cout", cout, r.cout);
        check("post_abort_lat",  lat,  4);

        // Single-digit instance
        run_op8(8'hFF, 8'hFF, 1'b1, 1'b0, lat);
        check("w8_sum",  sum8,  8'hFF);
        check("w8_cout", cout8, 1);
        check("w8_ovf",  ovf8,  0);
        check("w8_lat",  lat,   1);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] ra, rb, rbe, rsum;
            logic rc, rs, rcout, rovf;
            logic [8:0] full;
            ra = 8'($urandom); rb = 8'($urandom);
            rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            rbe   = rs ? ~rb : rb;
            full  = {1'b0, ra} + {1'b0, rbe} + 9'(rs ? 1'b1 : rc);
            rsum  = full[7:0];
            rcout = full[8];
            rovf  = (ra[7] == rbe[7]) && (rsum[7] != ra[7]);
            run_op8(ra, rb, rc, rs, lat);
            check($sformatf("w8_rnd%0d_sum", i),  sum8,  rsum);
            check($sformatf("w8_rnd%0d_cout", i), cout8, rcout);
            check($sformatf("w8_rnd%0d_ovf", i),  ovf8,  rovf);
            check($sformatf("w8_rnd%0d_lat", i),  lat,   1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
